cell_comm_tx_arbiter: RTL and testbench
=======================================

Name:
cell_comm_tx_arbiter

Overview:
- Packet-granular arbiter that shares one Aurora TX AXIS lane (CW or CCW) between two requesters.
- Requester 0 is the locally generated BPM FA packet stream. Requester 1 is the stream of packets forwarded from the opposite-direction RX.
- Sits between the BPM packet builder / forwarding FIFO and the Aurora core TX port, in the Aurora user clock domain; one instance per direction.
- Guarantees no interleaving inside a packet, drains requesters while the link is down, and truncates runaway packets.

Parameters:
- DATA_WIDTH, 32: AXIS tdata width.
- MAX_WORDS, 8: maximum packet length in words; legal range 2..255.
- CNT_WIDTH, 16: width of the saturating statistics counters.

Ports:
- axisUserClk  in  1  Aurora user clock; the only clock.
- axisUserResetN  in  1  synchronous active-low reset.
- channelUp  in  1  Aurora channel up.
- locTvalid / locTlast  in  1 / 1  local BPM stream.
- locTdata  in  DATA_WIDTH  local BPM stream data.
- locTready  out  1  local BPM stream ready.
- fwdTvalid / fwdTlast  in  1 / 1  forwarded stream.
- fwdTdata  in  DATA_WIDTH  forwarded stream data.
- fwdTready  out  1  forwarded stream ready.
- txTvalid / txTlast  out  1 / 1  to Aurora TX.
- txTdata  out  DATA_WIDTH  to Aurora TX.
- txTready  in  1  from Aurora TX.
- grant  out  2  one-hot current owner; 0 when idle.
- locPktCount, fwdPktCount  out  CNT_WIDTH  packets completed on TX, per source.
- dropCount  out  CNT_WIDTH  packets discarded while the link was down.
- truncCount  out  CNT_WIDTH  packets truncated at MAX_WORDS.

Behaviour:
- Clock and reset: single clock axisUserClk; synchronous, active-low reset axisUserResetN.
- Reset values: state=IDLE, grant=0, lastGrant=fwd (so local wins first), word counter=0, all counters=0, txTvalid=0, locTready=fwdTready=0.
- States: IDLE, PASS, DRAIN.

IDLE:
- No transfers; all readies are 0 and txTvalid=0.
- If channelUp=0 and any tvalid=1: latch that source (local first if both) and go to DRAIN with drop=1.
- Else if exactly one tvalid=1: grant it and go to PASS.
- If both tvalid=1: grant the source other than lastGrant (round robin), go to PASS, and update lastGrant.
- Arbitration costs one bubble cycle per packet.

PASS:
- Combinational pass-through from the granted source: txTvalid=srcTvalid, txTdata=srcTdata, srcTready=txTready. The non-granted ready is 0. Zero-cycle latency.
- A beat is a cycle with txTvalid&txTready. Each beat increments the word counter.
- txTlast = srcTlast OR (counter==MAX_WORDS-1).
- Beat with srcTlast: increment that source's packet counter, clear the counter, go to IDLE.
- Beat with counter==MAX_WORDS-1 and srcTlast=0: forced tlast. Increment that source's packet counter and truncCount, then go to DRAIN with drop=0.
- channelUp falling while in PASS: go to DRAIN next cycle with drop=1. txTvalid is forced to 0 from that cycle on.
  - The Aurora core discards the partial frame.
  - The packet is not counted in the packet counters.

DRAIN:
- txTvalid=0; the owning source's tready=1.
- Source beats are consumed and discarded until a beat with srcTlast.
- On that beat: increment dropCount if drop=1, clear grant and the counter, and go to IDLE.
- The drain itself is never truncated: the source must eventually present tlast.

Counters and boundary cases:
- All counters saturate at 2^CNT_WIDTH-1 and do not wrap.
- A single-word packet (tlast on the first beat) completes in PASS with one beat.
- tvalid dropping mid-packet: hold the grant and wait; no timeout.
- txTready held 0: hold indefinitely; the source sees tready=0.
- A reset asserted mid-packet returns everything to reset values at the next edge. No partial state survives.

Decomposition:
- Shared package cell_comm_pkg:
  - state enum {IDLE, PASS, DRAIN};
  - source index constants SRC_LOC=0, SRC_FWD=1;
  - a saturating-increment function reused by the counters.
- One natural sub-module: cell_comm_sat_counter (CNT_WIDTH, sync active-low clear, inc input), instantiated four times.
- The FSM and mux stay in the top module.

Test Plan:
1. Local-only 4-word packet, txTready=1, channelUp=1 -> 1 bubble, then 4 beats with tlast on beat 4; grant=01 for 4 cycles; locPktCount=1.
2. Both sources valid with 4-word packets, 3 packets each -> TX order loc,fwd,loc,fwd,loc,fwd; never interleaved; locPktCount=fwdPktCount=3.
3. Forwarded 12-word packet with MAX_WORDS=8 -> tlast forced on beat 8, remaining 4 words consumed with txTvalid=0; truncCount=1, fwdPktCount=1.
4. channelUp deasserted after beat 2 of a 4-word local packet -> txTvalid=0 from the next cycle; words 3–4 drained with locTready=1; dropCount=1, locPktCount=0.
5. txTready toggling 1,0,1,0 during a 4-word packet -> source ready mirrors txTready; data order preserved; packet completes after 4 accepted beats.
6. Reset (axisUserResetN=0 for 1 cycle) mid-PASS -> next cycle: grant=0, txTvalid=0, all counters=0; the first subsequent contention is granted to local.

Source files
------------

// File: rtl/cell_comm_pkg.sv
// rtl/cell_comm_pkg.sv - shared types, constants and helpers for the cell comm TX arbiter
package cell_comm_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PASS  = 2'd1,
      DRAIN = 2'd2
   } arbStateT;

   localparam logic SRC_LOC = 1'b0;
   localparam logic SRC_FWD = 1'b1;

   // Wide enough for a beat index up to 254 (MAX_WORDS tops out at 255)
   localparam int WORD_CNT_WIDTH = 8;

   // Increment that sticks at the all-ones value of a 'width'-bit counter
   function automatic logic [63:0] satInc(input logic [63:0] value, input int width);
      logic [63:0] maxVal;
      maxVal = (64'd1 << width) - 64'd1;
      return (value >= maxVal) ? value : value + 64'd1;
   endfunction

endpackage

// File: rtl/cell_comm_sat_counter.sv
// rtl/cell_comm_sat_counter.sv - saturating event counter with synchronous active-low clear
module cell_comm_sat_counter
   import cell_comm_pkg::*;
#(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 clearN,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] count
);

   // Count single-cycle events, holding at all-ones instead of wrapping
   always_ff @(posedge clk) begin
      if (!clearN) begin
         count <= '0;
      end else if (inc) begin
         count <= CNT_WIDTH'(satInc(64'(count), CNT_WIDTH));
      end
   end

endmodule

// File: rtl/cell_comm_tx_arbiter.sv
// rtl/cell_comm_tx_arbiter.sv - packet-granular round-robin arbiter for one Aurora TX lane
module cell_comm_tx_arbiter
   import cell_comm_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MAX_WORDS  = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  axisUserClk,
   input  logic                  axisUserResetN,
   input  logic                  channelUp,
   input  logic                  locTvalid,
   input  logic                  locTlast,
   input  logic [DATA_WIDTH-1:0] locTdata,
   output logic                  locTready,
   input  logic                  fwdTvalid,
   input  logic                  fwdTlast,
   input  logic [DATA_WIDTH-1:0] fwdTdata,
   output logic                  fwdTready,
   output logic                  txTvalid,
   output logic                  txTlast,
   output logic [DATA_WIDTH-1:0] txTdata,
   input  logic                  txTready,
   output logic [1:0]            grant,
   output logic [CNT_WIDTH-1:0]  locPktCount,
   output logic [CNT_WIDTH-1:0]  fwdPktCount,
   output logic [CNT_WIDTH-1:0]  dropCount,
   output logic [CNT_WIDTH-1:0]  truncCount
);

   localparam logic [WORD_CNT_WIDTH-1:0] LAST_IDX = WORD_CNT_WIDTH'(MAX_WORDS - 1);

   arbStateT                  state, stateNext;
   logic                      owner, ownerNext;
   logic                      lastGrant, lastGrantNext;
   logic                      dropFlag, dropNext;
   logic [WORD_CNT_WIDTH-1:0] wordCnt, wordCntNext;
   logic [1:0]                grantReg;

   logic                  srcValid;
   logic                  srcLast;
   logic [DATA_WIDTH-1:0] srcData;
   logic                  atLimit;
   logic                  pktDone;
   logic                  truncInc;
   logic                  dropInc;

   assign srcValid = (owner == SRC_FWD) ? fwdTvalid : locTvalid;
   assign srcLast  = (owner == SRC_FWD) ? fwdTlast  : locTlast;
   assign srcData  = (owner == SRC_FWD) ? fwdTdata  : locTdata;
   assign atLimit  = (wordCnt == LAST_IDX);
   assign grant    = grantReg;

   // State, owner, round-robin history and beat counter registers
   always_ff @(posedge axisUserClk) begin
      if (!axisUserResetN) begin
         state     <= IDLE;
         owner     <= SRC_LOC;
         lastGrant <= SRC_FWD;
         dropFlag  <= 1'b0;
         wordCnt   <= '0;
         grantReg  <= 2'b00;
      end else begin
         state     <= stateNext;
         owner     <= ownerNext;
         lastGrant <= lastGrantNext;
         dropFlag  <= dropNext;
         wordCnt   <= wordCntNext;
         grantReg  <= (stateNext == IDLE) ? 2'b00
                                          : {ownerNext == SRC_FWD, ownerNext == SRC_LOC};
      end
   end

   // Arbitration, pass-through mux, truncation and link-down draining
   always_comb begin
      stateNext     = state;
      ownerNext     = owner;
      lastGrantNext = lastGrant;
      dropNext      = dropFlag;
      wordCntNext   = wordCnt;
      txTvalid      = 1'b0;
      txTlast       = 1'b0;
      txTdata       = srcData;
      locTready     = 1'b0;
      fwdTready     = 1'b0;
      pktDone       = 1'b0;
      truncInc      = 1'b0;
      dropInc       = 1'b0;
      case (state)
         IDLE: begin
            if (locTvalid || fwdTvalid) begin
               if (!channelUp) begin
                  ownerNext = locTvalid ? SRC_LOC : SRC_FWD;
                  dropNext  = 1'b1;
                  stateNext = DRAIN;
               end else begin
                  if (locTvalid && fwdTvalid) begin
                     ownerNext = ~lastGrant;
                  end else begin
                     ownerNext = locTvalid ? SRC_LOC : SRC_FWD;
                  end
                  lastGrantNext = ownerNext;
                  dropNext      = 1'b0;
                  wordCntNext   = '0;
                  stateNext     = PASS;
               end
            end
         end
         PASS: begin
            if (!channelUp) begin
               // Partial frame is abandoned; the rest of the packet is drained
               stateNext   = DRAIN;
               dropNext    = 1'b1;
               wordCntNext = '0;
            end else begin
               txTvalid = srcValid;
               txTlast  = srcLast | atLimit;
               if (owner == SRC_FWD) begin
                  fwdTready = txTready;
               end else begin
                  locTready = txTready;
               end
               if (srcValid && txTready) begin
                  if (srcLast) begin
                     pktDone     = 1'b1;
                     wordCntNext = '0;
                     stateNext   = IDLE;
                  end else if (atLimit) begin
                     pktDone     = 1'b1;
                     truncInc    = 1'b1;
                     dropNext    = 1'b0;
                     wordCntNext = '0;
                     stateNext   = DRAIN;
                  end else begin
                     wordCntNext = wordCnt + 1'b1;
                  end
               end
            end
         end
         DRAIN: begin
            if (owner == SRC_FWD) begin
               fwdTready = 1'b1;
            end else begin
               locTready = 1'b1;
            end
            if (srcValid && srcLast) begin
               dropInc     = dropFlag;
               wordCntNext = '0;
               stateNext   = IDLE;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   cell_comm_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) uLocPktCnt (
      .clk    (axisUserClk),
      .clearN (axisUserResetN),
      .inc    (pktDone && (owner == SRC_LOC)),
      .count  (locPktCount)
   );

   cell_comm_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) uFwdPktCnt (
      .clk    (axisUserClk),
      .clearN (axisUserResetN),
      .inc    (pktDone && (owner == SRC_FWD)),
      .count  (fwdPktCount)
   );

   cell_comm_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) uDropCnt (
      .clk    (axisUserClk),
      .clearN (axisUserResetN),
      .inc    (dropInc),
      .count  (dropCount)
   );

   cell_comm_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) uTruncCnt (
      .clk    (axisUserClk),
      .clearN (axisUserResetN),
      .inc    (truncInc),
      .count  (truncCount)
   );

endmodule

// File: tb/tb_cell_comm_tx_arbiter.sv
// tb/tb_cell_comm_tx_arbiter.sv - randomized self-checking bench for cell_comm_tx_arbiter
module tb_cell_comm_tx_arbiter;

   localparam int DW   = 32;
   localparam int MAXW = 8;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          axisUserResetN = 1'b0;
   logic          channelUp = 1'b1;
   logic          locTvalid = 1'b0, locTlast = 1'b0, locTready;
   logic [DW-1:0] locTdata = '0;
   logic          fwdTvalid = 1'b0, fwdTlast = 1'b0, fwdTready;
   logic [DW-1:0] fwdTdata = '0;
   logic          txTvalid, txTlast;
   logic [DW-1:0] txTdata;
   logic          txTready = 1'b1;
   logic [1:0]    grant;
   logic [CW-1:0] locPktCount, fwdPktCount, dropCount, truncCount;

   always #5 clk = ~clk;

   cell_comm_tx_arbiter #(.DATA_WIDTH(DW), .MAX_WORDS(MAXW), .CNT_WIDTH(CW)) dut (
      .axisUserClk    (clk),
      .axisUserResetN (axisUserResetN),
      .channelUp      (channelUp),
      .locTvalid      (locTvalid),
      .locTlast       (locTlast),
      .locTdata       (locTdata),
      .locTready      (locTready),
      .fwdTvalid      (fwdTvalid),
      .fwdTlast       (fwdTlast),
      .fwdTdata       (fwdTdata),
      .fwdTready      (fwdTready),
      .txTvalid       (txTvalid),
      .txTlast        (txTlast),
      .txTdata        (txTdata),
      .txTready       (txTready),
      .grant          (grant),
      .locPktCount    (locPktCount),
      .fwdPktCount    (fwdPktCount),
      .dropCount      (dropCount),
      .truncCount     (truncCount)
   );

   int tests = 0;
   int failures = 0;
   int cycleNo = 0;
   logic [DW:0] locQ[$];
   logic [DW:0] fwdQ[$];
   logic [DW:0] expLoc[$];
   logic [DW:0] expFwd[$];
   int txOrder[$];
   int beatCycles[$];
   int txBeats = 0;
   int drainFires = 0;
   bit inPkt = 0;
   int pktSrc = 0;
   int validPct = 100;
   int readyPct = 100;
   bit toggleReady = 0;
   int mLoc = 0, mFwd = 0, mDrop = 0, mTrunc = 0;
   int locRiseCycle = -1;
   bit prevLocValid = 0;
   logic [1:0] sGrant;
   logic sLocReady, sFwdReady, sTxReady;

   function automatic int sat(input int v);
      return (v < CMAX) ? v + 1 : v;
   endfunction

   // One clock: observe at negedge (scoreboard), then drive new stimulus after posedge
   task automatic step();
      logic locFire, fwdFire, txFire;
      logic [DW:0] e;
      int src;
      @(negedge clk);
      cycleNo++;
      locFire = locTvalid & locTready;
      fwdFire = fwdTvalid & fwdTready;
      txFire = txTvalid & txTready;
      sGrant = grant;
      sLocReady = locTready;
      sFwdReady = fwdTready;
      sTxReady = txTready;
      if (locTvalid && !prevLocValid) locRiseCycle = cycleNo;
      prevLocValid = locTvalid;
      if ((locFire || fwdFire) && !txFire) drainFires++;
      if (!channelUp) begin
         tests++;
         if (txTvalid !== 1'b0) begin
            failures++;
            $display("FAIL tx_valid_link_down: txTvalid=%0b required 0 (cycle %0d)", txTvalid, cycleNo);
         end
      end
      if (txFire) begin
         txBeats++;
         beatCycles.push_back(cycleNo);
         tests++;
         if (grant != 2'b01 && grant != 2'b10) begin
            failures++;
            $display("FAIL grant_onehot: grant=%b required 01 or 10 (cycle %0d)", grant, cycleNo);
         end else begin
            src = (grant == 2'b10) ? 1 : 0;
            tests++;
            if (inPkt && src != pktSrc) begin
               failures++;
               $display("FAIL interleave: src=%0d required %0d (cycle %0d)", src, pktSrc, cycleNo);
            end
            tests++;
            if (((src == 0) ? fwdTready : locTready) !== 1'b0) begin
               failures++;
               $display("FAIL other_ready: non-granted ready=1 required 0 (cycle %0d)", cycleNo);
            end
            tests++;
            if (((src == 0) ? expLoc.size() : expFwd.size()) == 0) begin
               failures++;
               $display("FAIL tx_unexpected: beat from src=%0d data=%h, required none", src, txTdata);
            end else begin
               e = (src == 0) ? expLoc.pop_front() : expFwd.pop_front();
               tests++;
               if ({txTlast, txTdata} !== e) begin
                  failures++;
                  $display("FAIL tx_beat src=%0d: got last=%0b data=%h required last=%0b data=%h",
                           src, txTlast, txTdata, e[DW], e[DW-1:0]);
               end
            end
            inPkt = !txTlast;
            pktSrc = src;
            if (txTlast) txOrder.push_back(src);
         end
      end
      @(posedge clk);
      #1;
      if (locFire) void'(locQ.pop_front());
      if (fwdFire) void'(fwdQ.pop_front());
      if (!(locTvalid && !locFire)) begin
         if (locQ.size() > 0 && int'($urandom_range(99)) < validPct) begin
            locTvalid = 1'b1;
            {locTlast, locTdata} = locQ[0];
         end else begin
            locTvalid = 1'b0;
         end
      end
      if (!(fwdTvalid && !fwdFire)) begin
         if (fwdQ.size() > 0 && int'($urandom_range(99)) < validPct) begin
            fwdTvalid = 1'b1;
            {fwdTlast, fwdTdata} = fwdQ[0];
         end else begin
            fwdTvalid = 1'b0;
         end
      end
      if (toggleReady) txTready = !txTready;
      else txTready = (int'($urandom_range(99)) < readyPct);
   endtask

   // Queue a source packet and the TX beats / counter effects the rules imply for it
   task automatic add_packet(input int src, input int len, input bit linkUp);
      logic [DW:0] b;
      for (int i = 0; i < len; i++) begin
         b = {(i == len - 1), DW'($urandom)};
         if (src == 0) locQ.push_back(b);
         else fwdQ.push_back(b);
         if (linkUp && i < MAXW) begin
            b[DW] = (i == len - 1) || (i == MAXW - 1);
            if (src == 0) expLoc.push_back(b);
            else expFwd.push_back(b);
         end
      end
      if (linkUp) begin
         if (src == 0) mLoc = sat(mLoc);
         else mFwd = sat(mFwd);
         if (len > MAXW) mTrunc = sat(mTrunc);
      end else begin
         mDrop = sat(mDrop);
      end
   endtask

   task automatic run_until_done(input int budget, input string name);
      int n = 0;
      while ((locQ.size() != 0 || fwdQ.size() != 0) && n < budget) begin
         step();
         n++;
      end
      step();
      step();
      tests++;
      if (locQ.size() != 0 || fwdQ.size() != 0) begin
         failures++;
         $display("FAIL %s_timeout: %0d/%0d source beats left, required 0", name, locQ.size(), fwdQ.size());
      end
      tests++;
      if (expLoc.size() != 0 || expFwd.size() != 0) begin
         failures++;
         $display("FAIL %s_missing_tx: %0d/%0d expected beats never seen, required 0", name, expLoc.size(), expFwd.size());
      end
   endtask

   task automatic do_reset();
      axisUserResetN = 1'b0;
      locTvalid = 1'b0;
      fwdTvalid = 1'b0;
      locQ.delete();
      fwdQ.delete();
      expLoc.delete();
      expFwd.delete();
      inPkt = 0;
      prevLocValid = 0;
      mLoc = 0; mFwd = 0; mDrop = 0; mTrunc = 0;
      @(posedge clk);
      #1;
      axisUserResetN = 1'b1;
   endtask

   task automatic test_reset();
      axisUserResetN = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      axisUserResetN = 1'b1;
      @(negedge clk);
      tests++;
      if (grant !== 2'b00 || txTvalid !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: grant=%b txTvalid=%0b required 00/0", grant, txTvalid);
      end
      tests++;
      if (locTready !== 1'b0 || fwdTready !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready: loc=%0b fwd=%0b required 0/0", locTready, fwdTready);
      end
      tests++;
      if ({locPktCount, fwdPktCount, dropCount, truncCount} !== '0) begin
         failures++;
         $display("FAIL reset_counters: %0d %0d %0d %0d required all 0", locPktCount, fwdPktCount, dropCount, truncCount);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_local_only();
      channelUp = 1'b1; validPct = 100; readyPct = 100;
      add_packet(0, 4, 1);
      beatCycles.delete();
      locRiseCycle = -1;
      run_until_done(200, "local_only");
      tests++;
      if (beatCycles.size() != 4) begin
         failures++;
         $display("FAIL local_beat_count: got %0d beats required 4", beatCycles.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            tests++;
            if (beatCycles[i] != locRiseCycle + 1 + i) begin
               failures++;
               $display("FAIL local_beat_timing: beat %0d at cycle %0d required %0d", i, beatCycles[i], locRiseCycle + 1 + i);
            end
         end
      end
      tests++;
      if (locPktCount !== CW'(mLoc)) begin
         failures++;
         $display("FAIL local_pkt_count: got %0d required %0d", locPktCount, mLoc);
      end
   endtask

   task automatic test_both();
      do_reset();
      validPct = 100; readyPct = 100;
      for (int p = 0; p < 3; p++) begin
         add_packet(0, 4, 1);
         add_packet(1, 4, 1);
      end
      txOrder.delete();
      run_until_done(300, "both");
      tests++;
      if (txOrder.size() != 6) begin
         failures++;
         $display("FAIL rr_packet_count: got %0d packets required 6", txOrder.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            tests++;
            if (txOrder[i] != i % 2) begin
               failures++;
               $display("FAIL rr_order: packet %0d from src %0d required %0d", i, txOrder[i], i % 2);
            end
         end
      end
      tests++;
      if (locPktCount !== CW'(mLoc) || fwdPktCount !== CW'(mFwd)) begin
         failures++;
         $display("FAIL rr_pkt_counts: got %0d/%0d required %0d/%0d", locPktCount, fwdPktCount, mLoc, mFwd);
      end
   endtask

   task automatic test_truncate();
      int b0, d0;
      add_packet(1, 12, 1);
      b0 = txBeats;
      d0 = drainFires;
      run_until_done(300, "truncate");
      tests++;
      if (txBeats - b0 != MAXW || drainFires - d0 != 12 - MAXW) begin
         failures++;
         $display("FAIL trunc_beats: tx=%0d drained=%0d required %0d/%0d", txBeats - b0, drainFires - d0, MAXW, 12 - MAXW);
      end
      tests++;
      if (truncCount !== CW'(mTrunc) || fwdPktCount !== CW'(mFwd)) begin
         failures++;
         $display("FAIL trunc_counts: trunc=%0d fwd=%0d required %0d/%0d", truncCount, fwdPktCount, mTrunc, mFwd);
      end
   endtask

   task automatic test_link_down();
      logic [DW:0] b;
      int b0, d0, n;
      for (int i = 0; i < 4; i++) begin
         b = {(i == 3), DW'($urandom)};
         locQ.push_back(b);
         if (i < 2) expLoc.push_back(b);
      end
      mDrop = sat(mDrop);
      b0 = txBeats;
      d0 = drainFires;
      n = 0;
      while (txBeats - b0 < 2 && n < 100) begin
         step();
         n++;
      end
      channelUp = 1'b0;
      run_until_done(100, "link_down");
      inPkt = 0;
      tests++;
      if (txBeats - b0 != 2 || drainFires - d0 != 2) begin
         failures++;
         $display("FAIL link_down_beats: tx=%0d drained=%0d required 2/2", txBeats - b0, drainFires - d0);
      end
      tests++;
      if (dropCount !== CW'(mDrop) || locPktCount !== CW'(mLoc)) begin
         failures++;
         $display("FAIL link_down_counts: drop=%0d loc=%0d required %0d/%0d", dropCount, locPktCount, mDrop, mLoc);
      end
      channelUp = 1'b1;
   endtask

   task automatic test_link_down_idle();
      int b0;
      channelUp = 1'b0;
      add_packet(0, 3, 0);
      add_packet(1, 1, 0);
      add_packet(0, 1, 0);
      b0 = txBeats;
      run_until_done(100, "idle_drop");
      tests++;
      if (txBeats != b0 || dropCount !== CW'(mDrop)) begin
         failures++;
         $display("FAIL idle_drop: tx=%0d drop=%0d required 0/%0d", txBeats - b0, dropCount, mDrop);
      end
      channelUp = 1'b1;
   endtask

   task automatic test_ready_toggle();
      int b0, n;
      toggleReady = 1;
      txTready = 1'b1;
      add_packet(0, 4, 1);
      b0 = txBeats;
      n = 0;
      while (locQ.size() != 0 && n < 200) begin
         step();
         n++;
         if (sGrant == 2'b01) begin
            tests++;
            if (sLocReady !== sTxReady || sFwdReady !== 1'b0) begin
               failures++;
               $display("FAIL ready_mirror: locTready=%0b fwdTready=%0b required %0b/0", sLocReady, sFwdReady, sTxReady);
            end
         end
      end
      toggleReady = 0;
      step();
      step();
      tests++;
      if (txBeats - b0 != 4 || locPktCount !== CW'(mLoc) || locQ.size() != 0) begin
         failures++;
         $display("FAIL toggle_complete: beats=%0d loc=%0d required 4/%0d", txBeats - b0, locPktCount, mLoc);
      end
   endtask

   task automatic test_reset_mid_packet();
      int b0, n;
      add_packet(0, 6, 1);
      b0 = txBeats;
      n = 0;
      while (txBeats - b0 < 2 && n < 50) begin
         step();
         n++;
      end
      do_reset();
      @(negedge clk);
      tests++;
      if (grant !== 2'b00 || txTvalid !== 1'b0 || locTready !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset_outputs: grant=%b txTvalid=%0b locTready=%0b required 00/0/0", grant, txTvalid, locTready);
      end
      tests++;
      if ({locPktCount, fwdPktCount, dropCount, truncCount} !== '0) begin
         failures++;
         $display("FAIL mid_reset_counters: %0d %0d %0d %0d required all 0", locPktCount, fwdPktCount, dropCount, truncCount);
      end
      @(posedge clk);
      #1;
      txOrder.delete();
      add_packet(0, 3, 1);
      add_packet(1, 3, 1);
      run_until_done(200, "post_reset");
      tests++;
      if (txOrder.size() != 2 || txOrder[0] != 0) begin
         failures++;
         $display("FAIL post_reset_first_grant: got %0d packets, first src=%0d required 2/0",
                  txOrder.size(), (txOrder.size() > 0) ? txOrder[0] : -1);
      end
      tests++;
      if (locPktCount !== CW'(mLoc) || fwdPktCount !== CW'(mFwd)) begin
         failures++;
         $display("FAIL post_reset_counts: got %0d/%0d required %0d/%0d", locPktCount, fwdPktCount, mLoc, mFwd);
      end
   endtask

   task automatic test_random();
      channelUp = 1'b1;
      validPct = 70;
      readyPct = 60;
      for (int p = 0; p < 40; p++) begin
         add_packet(int'($urandom_range(1)), int'($urandom_range(12, 1)), 1);
      end
      run_until_done(5000, "random");
      tests++;
      if (locPktCount !== CW'(mLoc) || fwdPktCount !== CW'(mFwd)) begin
         failures++;
         $display("FAIL random_pkt_counts: got %0d/%0d required %0d/%0d", locPktCount, fwdPktCount, mLoc, mFwd);
      end
      tests++;
      if (truncCount !== CW'(mTrunc) || dropCount !== CW'(mDrop)) begin
         failures++;
         $display("FAIL random_trunc_drop: got %0d/%0d required %0d/%0d", truncCount, dropCount, mTrunc, mDrop);
      end
      validPct = 100;
      readyPct = 100;
   endtask

   initial begin
      test_reset();
      test_local_only();
      test_both();
      test_truncate();
      test_link_down();
      test_link_down_idle();
      test_ready_toggle();
      test_reset_mid_packet();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
